ntt_result_writeback: RTL and testbench
=======================================

# ntt_result_writeback

Write-back stage placed directly downstream of one NTT core's two butterflies. It collects the four 30-bit butterfly results per beat (r1..r4) and regroups two consecutive beats into 60-bit coefficient pairs. It then issues them as upper/lower BRAM writes (write_enable, upper/lower write address and data) for the next NTT stage. It also counts beats per stage, signals stage completion, and flags protocol violations.

## Interface

Parameters:
- PAIRS, 256: beat pairs per stage; a stage is 2*PAIRS valid beats.
- HALF_OFFSET, 9'd256: address offset of the second write of each pair.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- stage_start  in  1  one-cycle pulse that arms or restarts a stage.
- in_valid  in  1  r1..r4 carry a valid butterfly result this cycle.
- r1, r2  in  30 each  upper butterfly outputs A and B.
- r3, r4  in  30 each  lower butterfly outputs A and B.
- write_enable  out  1  shared write strobe for both BRAMs.
- upper_write_address  out  9  upper BRAM write address.
- upper_data_input  out  60  upper BRAM write data.
- lower_write_address  out  9  lower BRAM write address.
- lower_data_input  out  60  lower BRAM write data.
- busy  out  1  high while a stage is armed.
- done  out  1  one-cycle pulse marking stage completion.
- overflow  out  1  sticky protocol-error flag.

## Operation

States:
- IDLE: no stage armed.
- EVEN: waiting for the even beat of a pair.
- ODD: waiting for the odd beat of a pair.

Transitions:
- stage_start moves to EVEN from any state.
- Valid beat in EVEN: latch E = {r1,r2,r3,r4}, go to ODD.
- Valid beat in ODD (O = current r1..r4):
  - First write: upper = {O.r1, E.r1}, lower = {O.r3, E.r3} (E in bits [29:0]), both addresses w.
  - Second write, next cycle: upper = {O.r2, E.r2}, lower = {O.r4, E.r4}, both addresses (w + HALF_OFFSET) mod 512.
  - Set a pending flag for the second write, increment pair counter w, go to EVEN.
- After the second write of pair PAIRS-1: pulse done with that write, go to IDLE, busy drops.

Rules:
- The pending second write never collides with a first write, because odd beats are at least 2 cycles apart.
- An even beat arriving in the cycle of a second write is accepted normally.
- in_valid in IDLE: beat discarded, overflow set.
- stage_start while busy:
  - Aborts the stage: buffered E discarded, pending second write cancelled (no write that cycle).
  - w cleared, overflow set.
  - The new stage starts in EVEN.
- stage_start in IDLE clears overflow.
- in_valid in the same cycle as stage_start belongs to the new stage and is latched as its first even beat.
- Address arithmetic is 9-bit with wrap-around; data is concatenated with no modular arithmetic.

Reset (rst) values, regardless of state mid-stage:
- State IDLE; w = 0; pending = 0.
- write_enable, busy, done, overflow = 0.
- Both addresses 0; both data words 0.

## Timing

- All outputs are registered.
- Odd beat sampled at edge t: first write visible in cycle t+1, second write in cycle t+2.
- done high in cycle t+2 of the final pair only.
- busy rises the cycle after stage_start and falls the cycle after done.
- Address and data outputs hold their last value while write_enable = 0.
- Throughput: one beat per cycle sustained; no backpressure.
- A full stage takes 2*PAIRS beats, i.e. 2*PAIRS writes per BRAM.

## Test plan

1. Reset mid-stage:
   - Stimulus: rst after 3 beats.
   - Required: next cycle all outputs 0, busy 0; a following stage_start and 2 beats produce writes at address 0 and 256.
2. Single pair:
   - Stimulus: stage_start; beat E = (1,2,3,4); beat O = (5,6,7,8).
   - Required: cycle t+1: addr 0, upper {5,1}, lower {7,3}. Cycle t+2: addr 256, upper {6,2}, lower {8,4}.
3. Full stage, PAIRS = 256:
   - Stimulus: 512 back-to-back beats.
   - Required: 512 writes; first-write addresses 0..255; second-write addresses 256..511.
   - Required: done pulses exactly once, coincident with the write to 511; overflow stays 0.
4. Gapped input:
   - Stimulus: in_valid asserted every third cycle.
   - Required: identical addresses and data to scenario 3; write_enable low in all other cycles.
5. Protocol errors:
   - Stimulus: beat in IDLE.
   - Required: no write, overflow = 1.
   - Stimulus: stage_start after 1 beat.
   - Required: that beat discarded; the next pair writes at address 0.
   - Stimulus: stage_start from IDLE.
   - Required: overflow clears.
6. Abort during pending write:
   - Stimulus: stage_start in cycle t+1 after an odd beat.
   - Required: the first write still issues in t+1; no second write in t+2; w restarts at 0.

Source files
------------

// File: rtl/ntt_result_writeback_if.sv
// Write-back bundle between the NTT butterflies and the BRAM pair.
// Master drives beats and stage control; slave drives BRAM writes and status.
interface ntt_result_writeback_if;
  logic        stage_start;
  logic        in_valid;
  logic [29:0] r1;
  logic [29:0] r2;
  logic [29:0] r3;
  logic [29:0] r4;
  logic        write_enable;
  logic [8:0]  upper_write_address;
  logic [59:0] upper_data_input;
  logic [8:0]  lower_write_address;
  logic [59:0] lower_data_input;
  logic        busy;
  logic        done;
  logic        overflow;

  modport master (
    output stage_start,
    output in_valid,
    output r1,
    output r2,
    output r3,
    output r4,
    input  write_enable,
    input  upper_write_address,
    input  upper_data_input,
    input  lower_write_address,
    input  lower_data_input,
    input  busy,
    input  done,
    input  overflow
  );

  modport slave (
    input  stage_start,
    input  in_valid,
    input  r1,
    input  r2,
    input  r3,
    input  r4,
    output write_enable,
    output upper_write_address,
    output upper_data_input,
    output lower_write_address,
    output lower_data_input,
    output busy,
    output done,
    output overflow
  );
endinterface

// File: rtl/ntt_result_writeback.sv
// Pairs consecutive butterfly beats into 60-bit words and writes them
// to the upper/lower BRAMs as two writes per pair.
module ntt_result_writeback #(
  parameter int          PAIRS       = 256,
  parameter logic [8:0]  HALF_OFFSET = 9'd256
) (
  input logic                  clk,
  input logic                  rst,
  ntt_result_writeback_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    EVEN,
    ODD
  } state_t;

  localparam logic [8:0] LAST = 9'(PAIRS - 1);

  state_t       state_q;
  state_t       state_d;
  logic [8:0]   w_q;
  logic [8:0]   w_d;
  logic [119:0] e_q;
  logic [119:0] e_d;
  logic         pend_q;
  logic         pend_d;
  logic         pend_last_q;
  logic         pend_last_d;
  logic [8:0]   pend_addr_q;
  logic [8:0]   pend_addr_d;
  logic [59:0]  pend_up_q;
  logic [59:0]  pend_up_d;
  logic [59:0]  pend_lo_q;
  logic [59:0]  pend_lo_d;

  logic         we_q;
  logic         we_d;
  logic [8:0]   ua_q;
  logic [8:0]   ua_d;
  logic [59:0]  ud_q;
  logic [59:0]  ud_d;
  logic [8:0]   la_q;
  logic [8:0]   la_d;
  logic [59:0]  ld_q;
  logic [59:0]  ld_d;
  logic         busy_q;
  logic         busy_d;
  logic         done_q;
  logic         done_d;
  logic         ovf_q;
  logic         ovf_d;

  logic         armed;
  logic [119:0] beat;

  // A stage stays armed until its trailing second write has issued.
  assign armed = (state_q != IDLE) || pend_q;
  assign beat  = {bus.r1, bus.r2, bus.r3, bus.r4};

  // Next-state, pairing and write scheduling.
  always_comb begin
    state_d     = state_q;
    w_d         = w_q;
    e_d         = e_q;
    pend_d      = pend_q;
    pend_last_d = pend_last_q;
    pend_addr_d = pend_addr_q;
    pend_up_d   = pend_up_q;
    pend_lo_d   = pend_lo_q;
    we_d        = 1'b0;
    ua_d        = ua_q;
    ud_d        = ud_q;
    la_d        = la_q;
    ld_d        = ld_q;
    done_d      = 1'b0;
    ovf_d       = ovf_q;

    if (bus.stage_start) begin
      state_d = bus.in_valid ? ODD : EVEN;
      if (bus.in_valid) begin
        e_d = beat;
      end
      w_d    = 9'd0;
      pend_d = 1'b0;
      ovf_d  = armed;
    end else begin
      if (pend_q) begin
        we_d   = 1'b1;
        ua_d   = pend_addr_q;
        la_d   = pend_addr_q;
        ud_d   = pend_up_q;
        ld_d   = pend_lo_q;
        done_d = pend_last_q;
        pend_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ovf_d = 1'b1;
          end
        end
        EVEN: begin
          if (bus.in_valid) begin
            e_d     = beat;
            state_d = ODD;
          end
        end
        ODD: begin
          if (bus.in_valid) begin
            we_d        = 1'b1;
            ua_d        = w_q;
            la_d        = w_q;
            ud_d        = {bus.r1, e_q[119:90]};
            ld_d        = {bus.r3, e_q[59:30]};
            pend_d      = 1'b1;
            pend_last_d = (w_q == LAST);
            pend_addr_d = w_q + HALF_OFFSET;
            pend_up_d   = {bus.r2, e_q[89:60]};
            pend_lo_d   = {bus.r4, e_q[29:0]};
            w_d         = w_q + 9'd1;
            state_d     = (w_q == LAST) ? IDLE : EVEN;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // busy lingers one cycle past done.
    busy_d = (state_d != IDLE) || pend_d || done_d;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= 9'd0;
      e_q         <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_addr_q <= 9'd0;
      pend_up_q   <= '0;
      pend_lo_q   <= '0;
      we_q        <= 1'b0;
      ua_q        <= 9'd0;
      ud_q        <= '0;
      la_q        <= 9'd0;
      ld_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      w_q         <= w_d;
      e_q         <= e_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      pend_addr_q <= pend_addr_d;
      pend_up_q   <= pend_up_d;
      pend_lo_q   <= pend_lo_d;
      we_q        <= we_d;
      ua_q        <= ua_d;
      ud_q        <= ud_d;
      la_q        <= la_d;
      ld_q        <= ld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.write_enable        = we_q;
  assign bus.upper_write_address = ua_q;
  assign bus.upper_data_input    = ud_q;
  assign bus.lower_write_address = la_q;
  assign bus.lower_data_input    = ld_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign bus.overflow            = ovf_q;

endmodule

// File: tb/tb_ntt_result_writeback.sv
// Bench for ntt_result_writeback: directed vector table for corner cases,
// then full stages checked against a pair-indexed reference model.
module tb_ntt_result_writeback;

  localparam int PAIRS = 256;
  localparam int HALF  = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  ntt_result_writeback_if bus ();

  ntt_result_writeback #(
    .PAIRS       (PAIRS),
    .HALF_OFFSET (9'd256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ss;
    logic        iv;
    logic [29:0] r1;
    logic [29:0] r2;
    logic [29:0] r3;
    logic [29:0] r4;
    logic        we;
    logic [8:0]  ua;
    logic [59:0] ud;
    logic [8:0]  la;
    logic [59:0] ld;
    logic        busy;
    logic        done;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [8:0]  ua;
    logic [59:0] ud;
    logic [8:0]  la;
    logic [59:0] ld;
    logic        done;
  } wr_t;

  vec_t vq[$];

  function automatic logic [59:0] mk(input int hi, input int lo);
    logic [29:0] h;
    logic [29:0] l;
    h = 30'(hi);
    l = 30'(lo);
    return {h, l};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ss, input logic iv,
                       input logic [29:0] a, input logic [29:0] b,
                       input logic [29:0] c, input logic [29:0] d);
    bus.stage_start = ss;
    bus.in_valid    = iv;
    bus.r1          = a;
    bus.r2          = b;
    bus.r3          = c;
    bus.r4          = d;
  endtask

  task automatic row(input logic rs, input logic ss, input logic iv,
                     input int base, input logic we, input int addr,
                     input int uh, input int ul, input int lh,
                     input int ll, input logic bsy, input logic ovf);
    vec_t v;
    v.rst  = rs;
    v.ss   = ss;
    v.iv   = iv;
    v.r1   = 30'(base + 1);
    v.r2   = 30'(base + 2);
    v.r3   = 30'(base + 3);
    v.r4   = 30'(base + 4);
    v.we   = we;
    v.ua   = 9'(addr);
    v.la   = 9'(addr);
    v.ud   = mk(uh, ul);
    v.ld   = mk(lh, ll);
    v.busy = bsy;
    v.done = 1'b0;
    v.ovf  = ovf;
    vq.push_back(v);
  endtask

  task automatic run_stage(input int mode, input string tag);
    wr_t         exp_w[int];
    wr_t         w;
    wr_t         held;
    int          e[4];
    int          o[4];
    int          k;
    int          p;
    int          last_cyc;
    int          nw;
    int          nd;
    int          idx;
    logic        v;
    bit          finished;

    k        = 0;
    nw       = 0;
    nd       = 0;
    last_cyc = 1 << 30;
    finished = 0;
    held     = '{9'd0, 60'd0, 9'd0, 60'd0, 1'b0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);
    @(posedge clk);
    #1;
    chk({tag, " start busy"}, 64'(bus.busy), 64'd1);
    chk({tag, " start ovf"}, 64'(bus.overflow), 64'd0);

    for (int c = 0; c < 6000; c++) begin
      unique case (mode)
        0:       v = 1'b1;
        1:       v = (c % 3 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      if (k >= 2 * PAIRS) v = 1'b0;
      if (v) begin
        for (int j = 0; j < 4; j++) o[j] = int'($urandom() & 32'h3fff_ffff);
        if (k % 2 == 0) begin
          e = o;
        end else begin
          p = k / 2;
          w.ua   = 9'(p);
          w.la   = 9'(p);
          w.ud   = mk(o[0], e[0]);
          w.ld   = mk(o[2], e[2]);
          w.done = 1'b0;
          exp_w[c + 1] = w;
          w.ua   = 9'((p + HALF) % 512);
          w.la   = 9'((p + HALF) % 512);
          w.ud   = mk(o[1], e[1]);
          w.ld   = mk(o[3], e[3]);
          w.done = (p == PAIRS - 1);
          exp_w[c + 2] = w;
          if (p == PAIRS - 1) last_cyc = c + 2;
        end
        k++;
        drive(1'b0, 1'b1, 30'(o[0]), 30'(o[1]), 30'(o[2]), 30'(o[3]));
      end else begin
        drive(1'b0, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);
      end
      @(posedge clk);
      #1;
      idx = c + 1;
      if (exp_w.exists(idx)) begin
        held = exp_w[idx];
        chk({tag, " we"}, 64'(bus.write_enable), 64'd1);
      end else begin
        chk({tag, " we idle"}, 64'(bus.write_enable), 64'd0);
      end
      chk({tag, " ua"}, 64'(bus.upper_write_address), 64'(held.ua));
      chk({tag, " ud"}, 64'(bus.upper_data_input), 64'(held.ud));
      chk({tag, " la"}, 64'(bus.lower_write_address), 64'(held.la));
      chk({tag, " ld"}, 64'(bus.lower_data_input), 64'(held.ld));
      chk({tag, " done"}, 64'(bus.done),
          64'(exp_w.exists(idx) && exp_w[idx].done));
      chk({tag, " ovf"}, 64'(bus.overflow), 64'd0);
      chk({tag, " busy"}, 64'(bus.busy), 64'(idx <= last_cyc));
      if (bus.write_enable) nw++;
      if (bus.done) nd++;
      if (idx == last_cyc + 1) begin
        finished = 1;
        break;
      end
    end
    chk({tag, " finished"}, 64'(finished), 64'd1);
    chk({tag, " writes"}, 64'(nw), 64'(2 * PAIRS));
    chk({tag, " dones"}, 64'(nd), 64'd1);
  endtask

  initial begin
    drive(1'b0, 1'b0, 30'd0, 30'd0, 30'd0, 30'd0);

    row(0, 0, 0,  0, 0,   0,  0,  0,  0,  0, 0, 0);
    row(0, 0, 1,  8, 0,   0,  0,  0,  0,  0, 0, 1);
    row(0, 1, 0,  0, 0,   0,  0,  0,  0,  0, 1, 0);
    row(0, 0, 1,  0, 0,   0,  0,  0,  0,  0, 1, 0);
    row(0, 0, 1,  4, 1,   0,  5,  1,  7,  3, 1, 0);
    row(0, 0, 0,  0, 1, 256,  6,  2,  8,  4, 1, 0);
    row(0, 0, 0,  0, 0, 256,  6,  2,  8,  4, 1, 0);
    row(0, 0, 1, 10, 0, 256,  6,  2,  8,  4, 1, 0);
    row(0, 1, 0,  0, 0, 256,  6,  2,  8,  4, 1, 1);
    row(0, 0, 1, 20, 0, 256,  6,  2,  8,  4, 1, 1);
    row(0, 0, 1, 24, 1,   0, 25, 21, 27, 23, 1, 1);
    row(0, 1, 0,  0, 0,   0, 25, 21, 27, 23, 1, 1);
    row(0, 0, 1, 30, 0,   0, 25, 21, 27, 23, 1, 1);
    row(0, 0, 1, 34, 1,   0, 35, 31, 37, 33, 1, 1);
    row(0, 0, 0,  0, 1, 256, 36, 32, 38, 34, 1, 1);
    row(0, 0, 0,  0, 0, 256, 36, 32, 38, 34, 1, 1);
    row(0, 0, 1, 50, 0, 256, 36, 32, 38, 34, 1, 1);
    row(0, 0, 1, 54, 1,   1, 55, 51, 57, 53, 1, 1);
    row(0, 0, 1, 60, 1, 257, 56, 52, 58, 54, 1, 1);
    row(1, 0, 1, 70, 0,   0,  0,  0,  0,  0, 0, 0);
    row(0, 1, 1, 40, 0,   0,  0,  0,  0,  0, 1, 0);
    row(0, 0, 1, 44, 1,   0, 45, 41, 47, 43, 1, 0);
    row(0, 0, 0,  0, 1, 256, 46, 42, 48, 44, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vq[i]) begin
      rst = vq[i].rst;
      drive(vq[i].ss, vq[i].iv, vq[i].r1, vq[i].r2, vq[i].r3, vq[i].r4);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d we", i), 64'(bus.write_enable), 64'(vq[i].we));
      chk($sformatf("row%0d ua", i),
          64'(bus.upper_write_address), 64'(vq[i].ua));
      chk($sformatf("row%0d ud", i),
          64'(bus.upper_data_input), 64'(vq[i].ud));
      chk($sformatf("row%0d la", i),
          64'(bus.lower_write_address), 64'(vq[i].la));
      chk($sformatf("row%0d ld", i),
          64'(bus.lower_data_input), 64'(vq[i].ld));
      chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(vq[i].busy));
      chk($sformatf("row%0d done", i), 64'(bus.done), 64'(vq[i].done));
      chk($sformatf("row%0d ovf", i), 64'(bus.overflow), 64'(vq[i].ovf));
    end
    rst = 1'b0;

    run_stage(0, "b2b");
    run_stage(1, "gap3");
    run_stage(2, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
